// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, oversampling ratio and the common
// state encoding used by both the transmit and receive state machines.
package uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider: one-cycle tick every N clocks; clr restarts the count
// so the first tick lands N clocks after the clear.
module uart_baud_tick #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || cnt == W'(N - 1))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(N - 1));
endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable data width, parity and stop bits;
// 16x oversampled receiver with 3-sample majority vote and separate error flags.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEn,
  input  logic                 rx,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic                 rxParityErr,
  output logic                 rxFrameErr,
  output logic [DATA_BITS-1:0] out,
  input  logic                 txEn,
  input  logic                 txStart,
  input  logic [DATA_BITS-1:0] in,
  output logic                 txBusy,
  output logic                 txDone,
  output logic                 tx
);
  localparam int   TX_DIV     = CLOCK_RATE / BAUD_RATE;
  localparam int   RX_DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int   RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
  localparam logic ODD        = (PARITY == PARITY_ODD);

  // ---------------- transmitter ----------------
  state_t               tx_state, tx_state_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shreg, tx_shreg_n;
  logic                 tx_par, tx_par_n, tx_n, tx_done_n, tx_clr, tx_tick;

  uart_baud_tick #(.N(TX_DIV)) u_tx_tick (.clk(clk), .rst(rst), .clr(tx_clr), .tick(tx_tick));

  always_comb begin
    tx_state_n = tx_state;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_par_n   = tx_par;
    tx_done_n  = 1'b0;
    tx_clr     = 1'b0;
    tx_n       = 1'b1;
    if (tx_state == ST_IDLE) begin
      if (txEn && txStart) begin
        tx_state_n = ST_START;
        tx_bit_n   = '0;
        tx_shreg_n = in;
        tx_par_n   = (^in) ^ ODD;
        tx_clr     = 1'b1;
      end
    end else if (!txEn) begin
      tx_state_n = ST_IDLE;
    end else if (tx_tick) begin
      case (tx_state)
        ST_START: begin
          tx_state_n = ST_DATA;
          tx_bit_n   = '0;
        end
        ST_DATA: begin
          if (tx_bit == 4'(DATA_BITS - 1)) begin
            if (PARITY != PARITY_NONE) tx_state_n = ST_PARITY;
            else                       tx_state_n = ST_STOP;
            tx_bit_n = '0;
          end else begin
            tx_bit_n   = tx_bit + 4'd1;
            tx_shreg_n = tx_shreg >> 1;
          end
        end
        ST_PARITY: begin
          tx_state_n = ST_STOP;
          tx_bit_n   = '0;
        end
        ST_STOP: begin
          if (tx_bit == 4'(STOP_BITS - 1)) begin
            tx_state_n = ST_IDLE;
            tx_done_n  = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 4'd1;
          end
        end
        default: tx_state_n = ST_IDLE;
      endcase
    end
    // Line level is registered from the next state so tx is glitch-free.
    case (tx_state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = tx_shreg_n[0];
      ST_PARITY: tx_n = tx_par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      txDone   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_bit   <= tx_bit_n;
      tx_shreg <= tx_shreg_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
      txDone   <= tx_done_n;
    end
  end

  assign txBusy = (tx_state != ST_IDLE);

  // ---------------- receiver ----------------
  logic                 rx_s1, rx_s2, rx_s3, rx_fall, rx_maj;
  state_t               rx_state, rx_state_n;
  logic [3:0]           rx_cnt, rx_cnt_n, rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shreg, rx_shreg_n;
  logic                 v7, v7_n, v8, v8_n, perr, perr_n, ferr, ferr_n;
  logic                 rx_clr, rx_load, os_tick;

  uart_baud_tick #(.N(RX_DIV)) u_rx_tick (.clk(clk), .rst(rst), .clr(rx_clr), .tick(os_tick));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_maj  = (v7 & v8) | (v7 & rx_s2) | (v8 & rx_s2);

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    v7_n       = v7;
    v8_n       = v8;
    perr_n     = perr;
    ferr_n     = ferr;
    rx_clr     = 1'b0;
    rx_load    = 1'b0;
    if (!rxEn) begin
      rx_state_n = ST_IDLE;
    end else if (rx_state == ST_IDLE) begin
      if (rx_fall) begin
        rx_state_n = ST_START;
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        rx_clr     = 1'b1;
      end
    end else if (os_tick) begin
      rx_cnt_n = rx_cnt + 4'd1;
      if (rx_cnt == 4'd7) v7_n = rx_s2;
      if (rx_cnt == 4'd8) v8_n = rx_s2;
      if (rx_cnt == 4'd9) begin
        case (rx_state)
          ST_START:  if (rx_maj) rx_state_n = ST_IDLE;
          ST_DATA:   rx_shreg_n = {rx_maj, rx_shreg[DATA_BITS-1:1]};
          ST_PARITY: perr_n = rx_maj ^ (^rx_shreg) ^ ODD;
          ST_STOP:   if (!rx_maj) ferr_n = 1'b1;
          default:   ;
        endcase
      end
      // Finishing mid-stop-bit lets the next start edge be caught promptly.
      if (rx_cnt == 4'd10 && rx_state == ST_STOP && rx_bit == 4'(STOP_BITS - 1)) begin
        rx_load    = 1'b1;
        rx_state_n = ST_IDLE;
      end
      if (rx_cnt == 4'd15) begin
        case (rx_state)
          ST_START: begin
            rx_state_n = ST_DATA;
            rx_bit_n   = '0;
          end
          ST_DATA: begin
            if (rx_bit == 4'(DATA_BITS - 1)) begin
              if (PARITY != PARITY_NONE) rx_state_n = ST_PARITY;
              else                       rx_state_n = ST_STOP;
              rx_bit_n = '0;
            end else begin
              rx_bit_n = rx_bit + 4'd1;
            end
          end
          ST_PARITY: begin
            rx_state_n = ST_STOP;
            rx_bit_n   = '0;
          end
          ST_STOP: rx_bit_n = rx_bit + 4'd1;
          default: rx_state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state    <= ST_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shreg    <= '0;
      v7          <= 1'b1;
      v8          <= 1'b1;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      out         <= '0;
      rxParityErr <= 1'b0;
      rxFrameErr  <= 1'b0;
      rxDone      <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shreg <= rx_shreg_n;
      v7       <= v7_n;
      v8       <= v8_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      rxDone   <= rx_load;
      if (rx_load) begin
        out         <= rx_shreg;
        rxParityErr <= perr;
        rxFrameErr  <= ferr;
      end
    end
  end

  assign rxBusy = (rx_state != ST_IDLE);
endmodule

// File: tb/tb_uart_param.sv
// Directed bench: 8N1 pair (a<->b), 7E2 pair (c<->d), and an 8O1 receiver (e) driven by hand.
module tb_uart_param;
  localparam int CR = 1600000;
  localparam int BR = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       a_rxEn, a_rx, a_rxBusy, a_rxDone, a_rxPE, a_rxFE, a_txEn, a_txStart, a_txBusy, a_txDone, a_tx;
  logic [7:0] a_out, a_in;
  logic       b_rxEn, b_rx, b_rxBusy, b_rxDone, b_rxPE, b_rxFE, b_txEn, b_txStart, b_txBusy, b_txDone, b_tx;
  logic [7:0] b_out, b_in;
  logic       c_rxEn, c_rx, c_rxBusy, c_rxDone, c_rxPE, c_rxFE, c_txEn, c_txStart, c_txBusy, c_txDone, c_tx;
  logic [6:0] c_out, c_in;
  logic       d_rxEn, d_rx, d_rxBusy, d_rxDone, d_rxPE, d_rxFE, d_txEn, d_txStart, d_txBusy, d_txDone, d_tx;
  logic [6:0] d_out, d_in;
  logic       e_rxEn, e_rx, e_rxBusy, e_rxDone, e_rxPE, e_rxFE, e_txEn, e_txStart, e_txBusy, e_txDone, e_tx;
  logic [7:0] e_out, e_in;

  assign b_rx = a_tx;
  assign a_rx = b_tx;
  assign d_rx = c_tx;
  assign c_rx = d_tx;

  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rxEn(a_rxEn), .rx(a_rx), .rxBusy(a_rxBusy), .rxDone(a_rxDone),
    .rxParityErr(a_rxPE), .rxFrameErr(a_rxFE), .out(a_out), .txEn(a_txEn), .txStart(a_txStart),
    .in(a_in), .txBusy(a_txBusy), .txDone(a_txDone), .tx(a_tx));
  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst), .rxEn(b_rxEn), .rx(b_rx), .rxBusy(b_rxBusy), .rxDone(b_rxDone),
    .rxParityErr(b_rxPE), .rxFrameErr(b_rxFE), .out(b_out), .txEn(b_txEn), .txStart(b_txStart),
    .in(b_in), .txBusy(b_txBusy), .txDone(b_txDone), .tx(b_tx));
  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rxEn(c_rxEn), .rx(c_rx), .rxBusy(c_rxBusy), .rxDone(c_rxDone),
    .rxParityErr(c_rxPE), .rxFrameErr(c_rxFE), .out(c_out), .txEn(c_txEn), .txStart(c_txStart),
    .in(c_in), .txBusy(c_txBusy), .txDone(c_txDone), .tx(c_tx));
  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d (
    .clk(clk), .rst(rst), .rxEn(d_rxEn), .rx(d_rx), .rxBusy(d_rxBusy), .rxDone(d_rxDone),
    .rxParityErr(d_rxPE), .rxFrameErr(d_rxFE), .out(d_out), .txEn(d_txEn), .txStart(d_txStart),
    .in(d_in), .txBusy(d_txBusy), .txDone(d_txDone), .tx(d_tx));
  uart_param #(.CLOCK_RATE(CR), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .rxEn(e_rxEn), .rx(e_rx), .rxBusy(e_rxBusy), .rxDone(e_rxDone),
    .rxParityErr(e_rxPE), .rxFrameErr(e_rxFE), .out(e_out), .txEn(e_txEn), .txStart(e_txStart),
    .in(e_in), .txBusy(e_txBusy), .txDone(e_txDone), .tx(e_tx));

  int         a_done_cnt = 0;
  int         b_done_cnt = 0;
  int         d_done_cnt = 0;
  int         e_done_cnt = 0;
  int         a_done_cyc[$];
  logic [7:0] b_q[$];

  always @(posedge clk) begin
    if (a_txDone) begin a_done_cnt++; a_done_cyc.push_back(cyc); end
    if (b_rxDone) begin b_done_cnt++; b_q.push_back(b_out); end
    if (d_rxDone) d_done_cnt++;
    if (e_rxDone) e_done_cnt++;
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_tx, a_txBusy, a_txDone} !== 3'b100) begin
      failures++; $display("FAIL reset_tx got=%b exp=100", {a_tx, a_txBusy, a_txDone});
    end
    checks++;
    if ({a_rxBusy, a_rxDone, a_rxPE, a_rxFE} !== 4'b0000) begin
      failures++; $display("FAIL reset_rx got=%b exp=0000", {a_rxBusy, a_rxDone, a_rxPE, a_rxFE});
    end
    checks++;
    if (a_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", a_out); end
    checks++;
    if ({c_tx, d_tx, e_tx} !== 3'b111) begin failures++; $display("FAIL reset_idle_lines got=%b exp=111", {c_tx, d_tx, e_tx}); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_tx_8n1();
    logic [9:0] exp_bits;
    logic [7:0] got;
    int n;
    exp_bits = {1'b1, 8'h45, 1'b0};
    b_q.delete();
    @(negedge clk); a_in = 8'h45; a_txStart = 1'b1;
    @(posedge clk); #1; a_txStart = 1'b0;
    checks++;
    if ({a_tx, a_txBusy} !== 2'b01) begin failures++; $display("FAIL tx8_start got=%b exp=01", {a_tx, a_txBusy}); end
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (a_tx !== exp_bits[i]) begin failures++; $display("FAIL tx8_bit%0d got=%b exp=%b", i, a_tx, exp_bits[i]); end
      if (i < 9) begin repeat (16) @(posedge clk); #1; end
    end
    n = 152;
    while (a_txDone !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 161) begin failures++; $display("FAIL tx8_done_cycle got=%0d exp=161", n); end
    checks++;
    if (a_txBusy !== 1'b0) begin failures++; $display("FAIL tx8_busy_fall got=%b exp=0", a_txBusy); end
    repeat (20) @(posedge clk);
    #1;
    got = (b_q.size() > 0) ? b_q[0] : 8'hxx;
    checks++;
    if (b_q.size() != 1 || got !== 8'h45) begin
      failures++; $display("FAIL rx8_data count=%0d got=%h exp=1 frame of 45", b_q.size(), got);
    end
    checks++;
    if ({b_rxPE, b_rxFE} !== 2'b00) begin failures++; $display("FAIL rx8_flags got=%b exp=00", {b_rxPE, b_rxFE}); end
  endtask

  task automatic test_tx_7e2();
    logic [10:0] exp_bits;
    int n, d0;
    exp_bits = {2'b11, 1'b0, 7'h55, 1'b0};
    d0 = d_done_cnt;
    @(negedge clk); c_in = 7'h55; c_txStart = 1'b1;
    @(posedge clk); #1; c_txStart = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (c_tx !== exp_bits[i]) begin failures++; $display("FAIL tx7e2_bit%0d got=%b exp=%b", i, c_tx, exp_bits[i]); end
      if (i < 10) begin repeat (16) @(posedge clk); #1; end
    end
    n = 168;
    while (c_txDone !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 177) begin failures++; $display("FAIL tx7e2_done_cycle got=%0d exp=177", n); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (d_done_cnt - d0 != 1 || d_out !== 7'h55) begin
      failures++; $display("FAIL rx7e2_data frames=%0d got=%h exp=1 frame of 55", d_done_cnt - d0, d_out);
    end
    checks++;
    if ({d_rxPE, d_rxFE} !== 2'b00) begin failures++; $display("FAIL rx7e2_flags got=%b exp=00", {d_rxPE, d_rxFE}); end
  endtask

  task automatic drive_e(input logic [10:0] bits);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1; e_rx = bits[i];
      repeat (15) @(posedge clk);
    end
    @(posedge clk); #1; e_rx = 1'b1;
    repeat (24) @(posedge clk);
    #1;
  endtask

  task automatic test_rx_errors();
    int e0;
    // Odd parity of FF is 1; send 0 instead.
    e0 = e_done_cnt;
    drive_e({1'b1, 1'b0, 8'hFF, 1'b0});
    checks++;
    if (e_done_cnt - e0 != 1 || e_out !== 8'hFF) begin
      failures++; $display("FAIL rx_parity_data frames=%0d got=%h exp=1 frame of ff", e_done_cnt - e0, e_out);
    end
    checks++;
    if ({e_rxPE, e_rxFE} !== 2'b10) begin failures++; $display("FAIL rx_parity_flags got=%b exp=10", {e_rxPE, e_rxFE}); end
    // False start: a 5-clock glitch low.
    e0 = e_done_cnt;
    @(posedge clk); #1; e_rx = 1'b0;
    repeat (5) @(posedge clk);
    #1; e_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (e_rxBusy !== 1'b0 || e_done_cnt != e0) begin
      failures++; $display("FAIL rx_false_start busy=%b frames=%0d exp busy=0 frames=0", e_rxBusy, e_done_cnt - e0);
    end
    checks++;
    if ({e_out, e_rxPE} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL rx_false_start_hold got=%h/%b exp=ff/1", e_out, e_rxPE); end
    // Good parity (0F -> 1) but stop bit low.
    e0 = e_done_cnt;
    drive_e({1'b0, 1'b1, 8'h0F, 1'b0});
    checks++;
    if (e_done_cnt - e0 != 1 || e_out !== 8'h0F) begin
      failures++; $display("FAIL rx_frame_data frames=%0d got=%h exp=1 frame of 0f", e_done_cnt - e0, e_out);
    end
    checks++;
    if ({e_rxPE, e_rxFE} !== 2'b01) begin failures++; $display("FAIL rx_frame_flags got=%b exp=01", {e_rxPE, e_rxFE}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    int s, n;
    logic [23:0] got;
    vals[0] = 8'hA1; vals[1] = 8'h3C; vals[2] = 8'h7E;
    b_q.delete();
    s = a_done_cyc.size();
    @(negedge clk); a_in = vals[0]; a_txStart = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (a_txBusy !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (f < 2) a_in = vals[f + 1];
      else       a_txStart = 1'b0;
      n = 0;
      while (a_txDone !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    end
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (a_done_cyc.size() - s != 3) begin failures++; $display("FAIL stream_count got=%0d exp=3", a_done_cyc.size() - s); end
    else begin
      checks++;
      if (a_done_cyc[s + 1] - a_done_cyc[s] != 161 || a_done_cyc[s + 2] - a_done_cyc[s + 1] != 161) begin
        failures++;
        $display("FAIL stream_spacing got=%0d,%0d exp=161,161", a_done_cyc[s + 1] - a_done_cyc[s], a_done_cyc[s + 2] - a_done_cyc[s + 1]);
      end
    end
    got = (b_q.size() == 3) ? {b_q[0], b_q[1], b_q[2]} : 24'hxxxxxx;
    checks++;
    if (got !== 24'hA13C7E) begin failures++; $display("FAIL stream_rx got=%h count=%0d exp=a13c7e", got, b_q.size()); end
  endtask

  task automatic test_abort();
    int a0;
    a0 = a_done_cnt;
    @(negedge clk); a_in = 8'hC3; a_txStart = 1'b1;
    @(posedge clk); #1; a_txStart = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    checks++;
    if (a_tx !== 1'b0) begin failures++; $display("FAIL abort_pre_line got=%b exp=0", a_tx); end
    a_txEn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({a_tx, a_txBusy} !== 2'b10) begin failures++; $display("FAIL abort_line got=%b exp=10", {a_tx, a_txBusy}); end
    repeat (250) @(posedge clk);
    #1;
    checks++;
    if (a_done_cnt != a0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", a_done_cnt - a0); end
    a_txEn = 1'b1;
  endtask

  task automatic test_reset_mid();
    int a0, b0;
    @(negedge clk); a_in = 8'h00; a_txStart = 1'b1;
    @(posedge clk); #1; a_txStart = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    checks++;
    if ({a_tx, a_txBusy, b_rxBusy} !== 3'b011) begin failures++; $display("FAIL rstmid_pre got=%b exp=011", {a_tx, a_txBusy, b_rxBusy}); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_tx, a_txBusy, a_txDone} !== 3'b100) begin failures++; $display("FAIL rstmid_tx got=%b exp=100", {a_tx, a_txBusy, a_txDone}); end
    checks++;
    if ({b_rxBusy, b_rxDone, b_rxPE, b_rxFE, b_out} !== 12'h000) begin
      failures++; $display("FAIL rstmid_rx got=%b/%h exp=0000/00", {b_rxBusy, b_rxDone, b_rxPE, b_rxFE}, b_out);
    end
    a0 = a_done_cnt; b0 = b_done_cnt;
    @(negedge clk); rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (a_done_cnt != a0 || b_done_cnt != b0 || a_tx !== 1'b1) begin
      failures++; $display("FAIL rstmid_after txdone=%0d rxdone=%0d tx=%b exp 0/0/1", a_done_cnt - a0, b_done_cnt - b0, a_tx);
    end
  endtask

  initial begin
    a_rxEn = 1; a_txEn = 1; a_txStart = 0; a_in = '0;
    b_rxEn = 1; b_txEn = 1; b_txStart = 0; b_in = '0;
    c_rxEn = 1; c_txEn = 1; c_txStart = 0; c_in = '0;
    d_rxEn = 1; d_txEn = 1; d_txStart = 0; d_in = '0;
    e_rxEn = 1; e_txEn = 0; e_txStart = 0; e_in = '0; e_rx = 1'b1;
    test_reset();
    test_tx_8n1();
    test_tx_7e2();
    test_rx_errors();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
